div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative 32-bit MIPS DIV/DIVU unit: restoring shift-subtract, one quotient bit per cycle.
// Holds the pipeline through the divide and pulses div_valid with HI/LO results.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        E_div_en,
    input  logic        E_div_signed,
    input  logic [31:0] E_opdata1,
    input  logic [31:0] E_opdata2,
    input  logic        div_annul,
    output logic        E_div_stall,
    output logic        div_valid,
    output logic [31:0] div_hi,
    output logic [31:0] div_lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [4:0]  count_r;
    logic [63:0] acc_r;
    logic [63:0] acc_step_s;
    logic [31:0] divisor_r;
    logic        q_neg_r;
    logic        r_neg_r;
    logic        start_s;
    logic        start_zero_s;
    logic        last_step_s;
    logic [32:0] rem_shift_s;
    logic [32:0] diff_s;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        if (is_signed && v[31]) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [31:0] negate_if(input logic [31:0] v, input logic neg);
        if (neg) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (E_div_en && !div_annul) begin
                    if (E_opdata2 == 32'd0) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_BUSY;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (div_annul) begin
                    state_next_s = ST_IDLE;
                end else if (count_r == 5'd31) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Per-state control outputs; stall drops in DONE so the pipeline can advance
    always_comb begin
        start_s      = 1'b0;
        start_zero_s = 1'b0;
        last_step_s  = 1'b0;
        E_div_stall  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_s      = E_div_en & ~div_annul & (E_opdata2 != 32'd0);
                start_zero_s = E_div_en & ~div_annul & (E_opdata2 == 32'd0);
                E_div_stall  = E_div_en & ~div_annul;
            end
            ST_BUSY: begin
                last_step_s = ~div_annul & (count_r == 5'd31);
                E_div_stall = E_div_en & ~div_annul;
            end
            ST_DONE: E_div_stall = 1'b0;
            default: E_div_stall = 1'b0;
        endcase
    end

    // One restoring step; the shifted remainder needs 33 bits before the compare
    always_comb begin
        rem_shift_s = acc_r[63:31];
        diff_s      = rem_shift_s - {1'b0, divisor_r};
        if (diff_s[32] == 1'b0) begin
            acc_step_s = {diff_s[31:0], acc_r[30:0], 1'b1};
        end else begin
            acc_step_s = {rem_shift_s[31:0], acc_r[30:0], 1'b0};
        end
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r     <= 64'd0;
            divisor_r <= 32'd0;
            count_r   <= 5'd0;
            q_neg_r   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (start_s) begin
            acc_r     <= {32'd0, abs32(E_opdata1, E_div_signed)};
            divisor_r <= abs32(E_opdata2, E_div_signed);
            count_r   <= 5'd0;
            q_neg_r   <= E_div_signed & (E_opdata1[31] ^ E_opdata2[31]);
            r_neg_r   <= E_div_signed & E_opdata1[31];
        end else if (state_r == ST_BUSY) begin
            acc_r   <= acc_step_s;
            count_r <= count_r + 5'd1;
        end
    end

    // Result registers, loaded on entry to DONE and held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            div_valid <= 1'b0;
            div_hi    <= 32'd0;
            div_lo    <= 32'd0;
        end else if (start_zero_s) begin
            div_valid <= 1'b1;
            div_hi    <= E_opdata1;
            div_lo    <= 32'hFFFF_FFFF;
        end else if (last_step_s) begin
            div_valid <= 1'b1;
            div_hi    <= negate_if(acc_step_s[63:32], r_neg_r);
            div_lo    <= negate_if(acc_step_s[31:0], q_neg_r);
        end else begin
            div_valid <= 1'b0;
        end
    end

endmodule
